keypad_bcd_adder_n: RTL and testbench
=====================================

KEYPAD_BCD_ADDER_N -- requirements
Module: keypad_bcd_adder_n

Interface
REQ-001 SHALL have parameter DIGITS, default 2, BCD digits per operand (legal 1..8).
REQ-002 SHALL have parameter BLANK, default 4'hF, nibble code shown for a blanked digit.
REQ-003 SHALL have port clk  input  1  main clock, all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe; key_code is sampled only when high.
REQ-006 SHALL have port key_code  input  4  key code: 0-9 digit, 4'hA ADD, 4'hC CE, all others ignored.
REQ-007 SHALL have port disp_bcd  output  4*(DIGITS+1)  display digits, MSD first, for the seven-segment driver.
REQ-008 SHALL have port state  output  2  current state encoding.
REQ-009 SHALL have port busy  output  1  high while the addition is in progress.
REQ-010 SHALL have port sum_valid  output  1  one-cycle pulse when the sum becomes valid.

Function
REQ-011 SHALL implement states ENTER_A=0, ENTER_B=1, ADD=2, SHOW=3, each registered.
REQ-012 SHALL, for an accepted digit in ENTER_A/ENTER_B, shift the digit into the LSD of the active operand (operand = operand*10 + digit).
REQ-013 SHALL ignore digit keys once the active operand holds DIGITS significant digits; leading zeros do not count as significant.
REQ-014 SHALL, on ADD in ENTER_A, go to ENTER_B with B=0.
REQ-015 SHALL, on ADD in ENTER_B, go to ADD and clear the carry and digit index.
REQ-016 SHALL, in ADD, add one BCD digit pair per cycle from the LSD (digit sum > 9 means subtract 10 and carry 1).
REQ-017 SHALL remain in ADD exactly DIGITS cycles, then go to SHOW; the final carry becomes result digit DIGITS (0 or 1).
REQ-018 SHALL hold busy high exactly while state==ADD; if ADD is accepted at edge N, busy is high for cycles N+1..N+DIGITS.
REQ-019 SHALL pulse sum_valid high for exactly the first cycle in SHOW.
REQ-020 SHALL ignore every key while in ADD; no queueing.
REQ-021 SHALL, on a digit key in SHOW, clear A, B and the sum, load the digit into A, and go to ENTER_A.
REQ-022 SHALL ignore ADD in SHOW.
REQ-023 SHALL handle CE as follows: in ENTER_A clear A; in ENTER_B clear B and stay in ENTER_B; in SHOW clear everything and go to ENTER_A.
REQ-024 SHALL drive disp_bcd as follows: ENTER_A shows A; ENTER_B and ADD show B; SHOW shows the (DIGITS+1)-digit sum. In entry states the top digit is BLANK.
REQ-025 SHALL replace leading zero digits with BLANK; a zero value shows digit 0 as 0.
REQ-026 SHALL register disp_bcd so it updates the cycle after the causing event.
REQ-027 SHALL treat key_valid held high for multiple cycles as one key per cycle; debouncing is upstream.

Reset
REQ-028 SHALL, while clr is high, force: state=ENTER_A, A=B=sum=0, carry=0, busy=0, sum_valid=0, disp_bcd = BLANK...BLANK followed by 0.
REQ-029 SHALL let clr abort an ADD in progress, with no sum_valid pulse.

Verification (DIGITS=2)
REQ-030 SHALL check reset: assert clr -> disp_bcd=12'hFF0, state=0, busy=0, sum_valid=0.
REQ-031 SHALL check a basic add: keys 4,7,ADD,5,8,ADD -> busy 2 cycles, then disp_bcd=12'h105 with a sum_valid pulse.
REQ-032 SHALL check the carry boundary: 9,9,ADD,9,9,ADD -> disp_bcd=12'h198; 0,ADD,0,ADD -> disp_bcd=12'hFF0.
REQ-033 SHALL check digit overflow: keys 1,2,3 -> disp_bcd=12'hF12 (third digit ignored); leading zeros 0,0,5 -> 12'hFF5.
REQ-034 SHALL check keys during ADD: digit 3 strobed while busy -> ignored, result unchanged; clr mid-ADD -> REQ-028 values and no sum_valid pulse.
REQ-035 SHALL check CE: 1,2,ADD,3,4,CE,ADD -> disp_bcd=12'hF12; then digit 7 in SHOW -> ENTER_A with disp_bcd=12'hFF7.

Source files
------------

// File: rtl/keypad_bcd_adder_n.sv
// keypad_bcd_adder_n
//   Keypad-driven BCD adder. Two operands of DIGITS BCD digits are typed in
//   MSD first, ADD moves from A to B and then starts a digit-serial BCD add
//   (one digit pair per clock, LSD first). The (DIGITS+1)-digit sum is shown
//   until a new digit or CE starts the next calculation.
//
// Ports
//   clk       : clock, rising edge
//   clr       : asynchronous active-high reset
//   key_valid : one-cycle key strobe
//   key_code  : 0-9 digit, 4'hA ADD, 4'hC CE, other codes ignored
//   disp_bcd  : registered display nibbles, MSD first, leading zeros blanked
//   state     : 0 ENTER_A, 1 ENTER_B, 2 ADD, 3 SHOW
//   busy      : high while state == ADD
//   sum_valid : one-cycle pulse on the first SHOW cycle
module keypad_bcd_adder_n #(
    parameter int         DIGITS = 2,
    parameter logic [3:0] BLANK  = 4'hF
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    output logic [4*(DIGITS+1)-1:0]   disp_bcd,
    output logic [1:0]                state,
    output logic                      busy,
    output logic                      sum_valid
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ADD     = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_CE  = 4'hC;
    localparam logic [3:0] LAST    = 4'(DIGITS - 1);

    state_t                   st, st_n;
    logic [DIGITS-1:0][3:0]   a, a_n, b, b_n;
    logic [DIGITS:0][3:0]     sum, sum_n;
    logic [DIGITS:0][3:0]     disp_n;
    logic                     carry, carry_n;
    logic [3:0]               idx, idx_n;
    logic                     is_digit, is_add, is_ce;
    logic [4:0]               dsum;
    logic [3:0]               dig;
    logic                     cout;

    // Replace leading zeros with BLANK; digit 0 is always shown.
    function automatic logic [DIGITS:0][3:0] blank_lz(input logic [DIGITS:0][3:0] v);
        logic [DIGITS:0][3:0] r;
        logic                 lead;
        lead = 1'b1;
        r    = v;
        for (int i = DIGITS; i >= 1; i--) begin
            if (lead && v[i] == 4'h0) r[i] = BLANK;
            else                      lead = 1'b0;
        end
        return r;
    endfunction

    // Shift a digit into the LSD unless the operand already has DIGITS
    // significant digits (top digit nonzero); leading zeros don't count.
    function automatic logic [DIGITS-1:0][3:0] push_digit(input logic [DIGITS-1:0][3:0] v,
                                                          input logic [3:0] d);
        logic [DIGITS-1:0][3:0] r;
        r = v;
        if (v[DIGITS-1] == 4'h0) begin
            for (int i = DIGITS - 1; i >= 1; i--) r[i] = v[i-1];
            r[0] = d;
        end
        return r;
    endfunction

    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_add   = key_valid && (key_code == KEY_ADD);
        is_ce    = key_valid && (key_code == KEY_CE);

        // The adder always works on digit 0; operands shift right each ADD cycle.
        dsum = {1'b0, a[0]} + {1'b0, b[0]} + {4'b0, carry};
        if (dsum > 5'd9) begin
            dig  = 4'(dsum - 5'd10);
            cout = 1'b1;
        end else begin
            dig  = dsum[3:0];
            cout = 1'b0;
        end

        st_n    = st;
        a_n     = a;
        b_n     = b;
        sum_n   = sum;
        carry_n = carry;
        idx_n   = idx;

        case (st)
            ENTER_A: begin
                if (is_digit)      a_n = push_digit(a, key_code);
                else if (is_ce)    a_n = '0;
                else if (is_add) begin
                    b_n  = '0;
                    st_n = ENTER_B;
                end
            end
            ENTER_B: begin
                if (is_digit)      b_n = push_digit(b, key_code);
                else if (is_ce)    b_n = '0;
                else if (is_add) begin
                    carry_n = 1'b0;
                    idx_n   = 4'd0;
                    sum_n   = '0;
                    st_n    = ADD;
                end
            end
            ADD: begin
                // Result digits enter at the top of the low DIGITS slots and
                // shift down, so after DIGITS cycles the LSD lands in slot 0.
                for (int i = 0; i < DIGITS - 1; i++) sum_n[i] = sum[i+1];
                sum_n[DIGITS-1] = dig;
                for (int i = 0; i < DIGITS - 1; i++) begin
                    a_n[i] = a[i+1];
                    b_n[i] = b[i+1];
                end
                a_n[DIGITS-1] = 4'h0;
                b_n[DIGITS-1] = 4'h0;
                carry_n = cout;
                idx_n   = idx + 4'd1;
                if (idx == LAST) begin
                    sum_n[DIGITS] = {3'b000, cout};
                    st_n          = SHOW;
                end
            end
            SHOW: begin
                if (is_digit) begin
                    a_n     = '0;
                    a_n[0]  = key_code;
                    b_n     = '0;
                    sum_n   = '0;
                    carry_n = 1'b0;
                    st_n    = ENTER_A;
                end else if (is_ce) begin
                    a_n     = '0;
                    b_n     = '0;
                    sum_n   = '0;
                    carry_n = 1'b0;
                    st_n    = ENTER_A;
                end
            end
            default: st_n = ENTER_A;
        endcase

        // Display follows the next-state view so it lands one cycle after the
        // key. During ADD the B operand is being consumed, so the view of B
        // latched on ADD entry is simply held.
        disp_n = disp_bcd;
        case (st_n)
            ENTER_A: disp_n = blank_lz({4'h0, a_n});
            ENTER_B: disp_n = blank_lz({4'h0, b_n});
            ADD:     if (st != ADD) disp_n = blank_lz({4'h0, b_n});
            SHOW:    disp_n = blank_lz(sum_n);
            default: disp_n = disp_bcd;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st        <= ENTER_A;
            a         <= '0;
            b         <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            idx       <= 4'd0;
            busy      <= 1'b0;
            sum_valid <= 1'b0;
            disp_bcd  <= {{DIGITS{BLANK}}, 4'h0};
        end else begin
            st        <= st_n;
            a         <= a_n;
            b         <= b_n;
            sum       <= sum_n;
            carry     <= carry_n;
            idx       <= idx_n;
            busy      <= (st_n == ADD);
            sum_valid <= (st_n == SHOW) && (st != SHOW);
            disp_bcd  <= disp_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_keypad_bcd_adder_n.sv
module tb_keypad_bcd_adder_n;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_CE  = 4'hC;

    logic        clk = 1'b0;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] disp_bcd;
    logic [1:0]  state;
    logic        busy;
    logic        sum_valid;

    int errors = 0;
    int checks = 0;

    keypad_bcd_adder_n #(.DIGITS(2), .BLANK(4'hF)) dut (
        .clk       (clk),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .disp_bcd  (disp_bcd),
        .state     (state),
        .busy      (busy),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; strobes one key across the next rising edge.
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Called right after ADD was accepted in ENTER_B (edge N).
    task automatic finish_add(input string tag, input logic [11:0] exp, input logic poke);
        chk({tag, "_busy1"}, busy, 1);
        chk({tag, "_st_add"}, state, 2);
        if (poke) press(4'd3);     // sampled during ADD, must be ignored
        else      @(negedge clk);
        chk({tag, "_busy2"}, busy, 1);
        chk({tag, "_sv_early"}, sum_valid, 0);
        @(negedge clk);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_st_show"}, state, 3);
        chk({tag, "_sv_pulse"}, sum_valid, 1);
        chk({tag, "_disp"}, disp_bcd, exp);
        @(negedge clk);
        chk({tag, "_sv_drop"}, sum_valid, 0);
        chk({tag, "_disp_hold"}, disp_bcd, exp);
    endtask

    initial begin
        int sv_seen;
        clr       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_disp", disp_bcd, 12'hFF0);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sv", sum_valid, 0);
        clr = 1'b0;
        @(negedge clk);

        // 47 + 58 = 105
        press(4'd4);
        chk("a_4", disp_bcd, 12'hFF4);
        press(4'd7);
        chk("a_47", disp_bcd, 12'hF47);
        press(4'hB);               // unused code
        chk("ign_code", disp_bcd, 12'hF47);
        press(K_ADD);
        chk("to_b_state", state, 1);
        chk("to_b_disp", disp_bcd, 12'hFF0);
        press(4'd5);
        press(4'd8);
        chk("b_58", disp_bcd, 12'hF58);
        press(K_ADD);
        finish_add("add47_58", 12'h105, 1'b0);

        // 99 + 99 = 198, starting from SHOW with digit 9
        press(4'd9);
        chk("show_digit_st", state, 0);
        press(4'd9);
        press(K_ADD);
        press(4'd9);
        press(4'd9);
        press(K_ADD);
        finish_add("add99_99", 12'h198, 1'b0);

        // 0 + 0 shows a single 0
        press(4'd0);
        press(K_ADD);
        press(4'd0);
        press(K_ADD);
        finish_add("add0_0", 12'hFF0, 1'b0);

        // Digit overflow and leading zeros
        press(K_CE);
        chk("ce_show_st", state, 0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("ovf_123", disp_bcd, 12'hF12);
        do_reset();
        press(4'd0);
        press(4'd0);
        press(4'd5);
        chk("lz_005", disp_bcd, 12'hFF5);

        // Key strobed during ADD: 25 + 17 = 42
        do_reset();
        press(4'd2);
        press(4'd5);
        press(K_ADD);
        press(4'd1);
        press(4'd7);
        press(K_ADD);
        finish_add("poke", 12'hF42, 1'b1);

        // CE in ENTER_B: 12 + 0 = 12
        do_reset();
        press(4'd1);
        press(4'd2);
        press(K_ADD);
        press(4'd3);
        press(4'd4);
        chk("b_34", disp_bcd, 12'hF34);
        press(K_CE);
        chk("ce_b_st", state, 1);
        chk("ce_b_disp", disp_bcd, 12'hFF0);
        press(K_ADD);
        finish_add("ce_add", 12'hF12, 1'b0);
        press(K_ADD);              // ignored in SHOW
        chk("show_add_st", state, 3);
        chk("show_add_disp", disp_bcd, 12'hF12);
        press(4'd7);
        chk("show7_st", state, 0);
        chk("show7_disp", disp_bcd, 12'hFF7);

        // clr aborts an ADD
        press(K_ADD);
        press(4'd6);
        press(K_ADD);
        chk("abort_busy", busy, 1);
        clr = 1'b1;
        #1;
        chk("abort_disp", disp_bcd, 12'hFF0);
        chk("abort_state", state, 0);
        chk("abort_busy0", busy, 0);
        @(negedge clk);
        clr = 1'b0;
        sv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (sum_valid) sv_seen++;
            @(negedge clk);
        end
        chk("abort_no_sv", sv_seen, 0);
        chk("abort_idle_st", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
